// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and constants for the RC4 keystream generator
package rc4_pkg;

    localparam int SBOX_DEPTH        = 256;
    localparam int BYTE_W            = 8;
    localparam int KEY_BYTES_DEFAULT = 5;
    localparam int KIDX_W            = 3;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_KSA_J,
        ST_KSA_SW,
        ST_PG_I,
        ST_PG_J,
        ST_PG_SW,
        ST_PG_OUT,
        ST_HOLD
    } rc4_state_e;

endpackage

// File: rtl/rc4_keystream_gen_if.sv
// rtl/rc4_keystream_gen_if.sv - control and keystream stream bundle
// master: drives key/start and ks_ready; slave: the generator itself.
interface rc4_keystream_gen_if #(
    parameter int KEY_BYTES = rc4_pkg::KEY_BYTES_DEFAULT
);
    logic [8*KEY_BYTES-1:0] key;
    logic                   start;
    logic                   busy;
    logic                   init_done;
    logic                   ks_valid;
    logic                   ks_ready;
    logic [7:0]             ks_byte;

    modport master (
        output key, start, ks_ready,
        input  busy, init_done, ks_valid, ks_byte
    );

    modport slave (
        input  key, start, ks_ready,
        output busy, init_done, ks_valid, ks_byte
    );
endinterface

// File: rtl/rc4_sbox_regfile.sv
// rtl/rc4_sbox_regfile.sv - 256x8 S-box, two async read ports, two sync write ports
// Ports: clk; rd_a/rd_b address in, data out (combinational);
//        wr_a/wr_b enable, address, data (written on rising clk).
module rc4_sbox_regfile
    import rc4_pkg::*;
(
    input  logic  clk,
    input  byte_t rd_a_addr_i,
    output byte_t rd_a_data_o,
    input  byte_t rd_b_addr_i,
    output byte_t rd_b_data_o,
    input  logic  wr_a_en_i,
    input  byte_t wr_a_addr_i,
    input  byte_t wr_a_data_i,
    input  logic  wr_b_en_i,
    input  byte_t wr_b_addr_i,
    input  byte_t wr_b_data_i
);

    byte_t mem_q [SBOX_DEPTH];

    assign rd_a_data_o = mem_q[rd_a_addr_i];
    assign rd_b_data_o = mem_q[rd_b_addr_i];

    // A swap with i==j writes the same value through both ports, so the
    // ordering of the two writes does not matter.
    always_ff @(posedge clk) begin
        if (wr_a_en_i) mem_q[wr_a_addr_i] <= wr_a_data_i;
        if (wr_b_en_i) mem_q[wr_b_addr_i] <= wr_b_data_i;
    end

endmodule

// File: rtl/rc4_keystream_gen.sv
// rtl/rc4_keystream_gen.sv - sequential RC4 KSA + PRGA keystream generator
// Ports: clk, rst (async, active high);
//        ks_if.slave: key/start (rekey request), busy, init_done,
//        ks_valid/ks_ready/ks_byte (registered keystream byte stream).
module rc4_keystream_gen
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    rc4_keystream_gen_if.slave  ks_if
);

    rc4_state_e             state_q, state_d;
    byte_t                  i_q, i_d;
    byte_t                  j_q, j_d;
    byte_t                  t_q, t_d;
    logic [KIDX_W-1:0]      kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic                   init_q, init_d;
    logic                   valid_q, valid_d;
    byte_t                  byte_q, byte_d;

    byte_t rd_a_addr, rd_a_data, rd_b_data;
    logic  wr_a_en, wr_b_en;
    byte_t wr_a_addr, wr_a_data, wr_b_addr, wr_b_data;
    byte_t kbyte;
    logic  in_pg;

    rc4_sbox_regfile u_sbox (
        .clk         (clk),
        .rd_a_addr_i (rd_a_addr),
        .rd_a_data_o (rd_a_data),
        .rd_b_addr_i (j_q),
        .rd_b_data_o (rd_b_data),
        .wr_a_en_i   (wr_a_en),
        .wr_a_addr_i (wr_a_addr),
        .wr_a_data_i (wr_a_data),
        .wr_b_en_i   (wr_b_en),
        .wr_b_addr_i (wr_b_addr),
        .wr_b_data_i (wr_b_data)
    );

    // K[0] is the most significant key byte.
    always_comb begin
        kbyte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KIDX_W'(b)) kbyte = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
    end

    assign in_pg = (state_q == ST_PG_I) || (state_q == ST_PG_J) || (state_q == ST_PG_SW) ||
                   (state_q == ST_PG_OUT) || (state_q == ST_HOLD);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        t_d       = t_q;
        kidx_d    = kidx_q;
        key_d     = key_q;
        init_d    = init_q;
        valid_d   = valid_q;
        byte_d    = byte_q;
        rd_a_addr = i_q;
        wr_a_en   = 1'b0;
        wr_a_addr = i_q;
        wr_a_data = rd_b_data;
        wr_b_en   = 1'b0;
        wr_b_addr = j_q;
        wr_b_data = rd_a_data;

        case (state_q)
            ST_IDLE: begin
                if (ks_if.start) begin
                    key_d   = ks_if.key;
                    i_d     = '0;
                    init_d  = 1'b0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                wr_a_en   = 1'b1;
                wr_a_data = i_q;
                i_d       = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = ST_KSA_J;
                end
            end
            ST_KSA_J: begin
                j_d     = j_q + rd_a_data + kbyte;
                state_d = ST_KSA_SW;
            end
            ST_KSA_SW: begin
                wr_a_en = 1'b1;
                wr_b_en = 1'b1;
                if (i_q == 8'hFF) begin
                    i_d     = '0;
                    j_d     = '0;
                    init_d  = 1'b1;
                    state_d = ST_PG_I;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
                    state_d = ST_KSA_J;
                end
            end
            ST_PG_I: begin
                i_d     = i_q + 8'd1;
                state_d = ST_PG_J;
            end
            ST_PG_J: begin
                j_d     = j_q + rd_a_data;
                state_d = ST_PG_SW;
            end
            ST_PG_SW: begin
                // Sum is swap-invariant, so take it from the pre-swap reads.
                wr_a_en = 1'b1;
                wr_b_en = 1'b1;
                t_d     = rd_a_data + rd_b_data;
                state_d = ST_PG_OUT;
            end
            ST_PG_OUT: begin
                // Table already holds post-swap data, so t==i or t==j is safe.
                rd_a_addr = t_q;
                byte_d    = rd_a_data;
                valid_d   = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (valid_q && ks_if.ks_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_PG_I;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Rekey during generation wins over any pending handshake.
        if (ks_if.start && in_pg) begin
            valid_d = 1'b0;
            key_d   = ks_if.key;
            i_d     = '0;
            init_d  = 1'b0;
            wr_a_en = 1'b0;
            wr_b_en = 1'b0;
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            t_q     <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
            init_q  <= 1'b0;
            valid_q <= 1'b0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            t_q     <= t_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
            init_q  <= init_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
        end
    end

    assign ks_if.busy      = (state_q == ST_FILL) || (state_q == ST_KSA_J) || (state_q == ST_KSA_SW);
    assign ks_if.init_done = init_q;
    assign ks_if.ks_valid  = valid_q;
    assign ks_if.ks_byte   = byte_q;

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// tb/tb_rc4_keystream_gen.sv - directed self-checking bench for rc4_keystream_gen
module tb_rc4_keystream_gen;

    logic clk;
    logic rst;

    rc4_keystream_gen_if #(.KEY_BYTES(5)) bus ();

    rc4_keystream_gen #(.KEY_BYTES(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .ks_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] key;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] exp_q [64];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic model(input logic [39:0] k, input int n);
        logic [7:0] s [256];
        logic [7:0] tmp;
        int ii, jj;
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        jj = 0;
        for (int a = 0; a < 256; a++) begin
            jj = (jj + int'(s[a]) + int'(k[8*(4 - a % 5) +: 8])) % 256;
            tmp = s[a]; s[a] = s[jj]; s[jj] = tmp;
        end
        ii = 0; jj = 0;
        for (int c = 0; c < n; c++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(s[ii])) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            exp_q[c] = s[(int'(s[ii]) + int'(s[jj])) % 256];
        end
    endtask

    task automatic pulse_start(input logic [39:0] k);
        @(negedge clk);
        bus.key   = k;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Starts a key, optionally pokes a second start at offset extra_at,
    // and checks busy/init_done/ks_valid timing relative to the accepted edge.
    task automatic kick_and_check(input logic [39:0] k, input int extra_at);
        bus.ks_ready = 1'b0;
        pulse_start(k);
        check("valid_after_start", 32'(bus.ks_valid), 32'd0);
        for (int c = 1; c <= 772; c++) begin
            @(negedge clk);
            if (extra_at > 0 && c == extra_at) begin
                bus.key   = 40'hFFFFFFFFFF;
                bus.start = 1'b1;
            end
            if (extra_at > 0 && c == extra_at + 1) begin
                bus.start = 1'b0;
                bus.key   = k;
            end
            if (c == 2)   check("busy_early", 32'(bus.busy), 32'd1);
            if (c == 767) check("busy_767", {bus.busy, bus.init_done}, 32'b10);
            if (c == 768) check("busy_768", {bus.busy, bus.init_done}, 32'b01);
            if (c == 771) check("valid_771", 32'(bus.ks_valid), 32'd0);
            if (c == 772) check("valid_772", 32'(bus.ks_valid), 32'd1);
        end
    endtask

    task automatic get_byte(input bit rnd, output logic [7:0] b);
        bit got  = 1'b0;
        bit seen = 1'b0;
        logic [7:0] first = 8'h00;
        b = 8'h00;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            bus.ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.ks_valid) begin
                if (seen) check("hold_stable", 32'(bus.ks_byte), 32'(first));
                else begin
                    seen  = 1'b1;
                    first = bus.ks_byte;
                end
                if (bus.ks_ready) begin
                    b   = first;
                    got = 1'b1;
                end
            end
        end
        if (!got) check("get_byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_table(input bit rnd, input int n);
        logic [7:0] b;
        for (int v = 0; v < n; v++) begin
            get_byte(rnd, b);
            check($sformatf("rfc_byte%0d", v), 32'(b), 32'(tbl[v].exp_byte));
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_busy"},  32'(bus.busy), 32'd0);
        check({nm, "_init"},  32'(bus.init_done), 32'd0);
        check({nm, "_valid"}, 32'(bus.ks_valid), 32'd0);
        check({nm, "_byte"},  32'(bus.ks_byte), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] rfc [8];
        rfc = '{8'hb2, 8'h39, 8'h63, 8'h05, 8'hf0, 8'h3d, 8'hc0, 8'h27};
        for (int v = 0; v < 8; v++) begin
            tbl[v].key      = 40'h0102030405;
            tbl[v].exp_byte = rfc[v];
        end

        rst          = 1'b1;
        bus.key      = '0;
        bus.start    = 1'b0;
        bus.ks_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // RFC 6229 vector, ready held high
        kick_and_check(tbl[0].key, 0);
        apply_table(1'b0, 8);

        // Same key, random backpressure
        kick_and_check(tbl[0].key, 0);
        apply_table(1'b1, 8);

        // Extra start during KSA must be ignored
        kick_and_check(tbl[0].key, 300);
        apply_table(1'b0, 8);

        // Rekey after three bytes, while a byte is held
        kick_and_check(tbl[0].key, 0);
        apply_table(1'b0, 3);
        bus.ks_ready = 1'b0;
        for (int c = 0; c < 20 && !bus.ks_valid; c++) @(negedge clk);
        check("held_before_rekey", 32'(bus.ks_valid), 32'd1);
        kick_and_check(tbl[0].key, 0);
        apply_table(1'b0, 3);

        // Async reset during KSA
        pulse_start(tbl[0].key);
        repeat (400) @(negedge clk);
        check("busy_pre_rst", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_ksa");
        @(negedge clk);
        rst = 1'b0;

        // Async reset during HOLD, then fresh key reproduces RFC
        kick_and_check(tbl[0].key, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        kick_and_check(tbl[0].key, 0);
        apply_table(1'b0, 8);

        // All-zero key against software model, 40 bytes
        model(40'h0, 40);
        kick_and_check(40'h0, 0);
        for (int v = 0; v < 40; v++) begin
            get_byte(1'b1, b);
            check($sformatf("zero_key_byte%0d", v), 32'(b), 32'(exp_q[v]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
